// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART <-> ALU frame handler.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEFAULT_OP_WIDTH = 6;
  localparam int DEFAULT_TIMEOUT  = 1000000;

  typedef enum logic [5:0] {
    ST_OPA     = 6'b000001,
    ST_OPB     = 6'b000010,
    ST_OPCODE  = 6'b000100,
    ST_EXEC    = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_WAIT_TX = 6'b100000
  } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bundle of rx byte, ALU operand/result and tx handshake signals around the frame handler.
interface uart_alu_if #(
  parameter int OP_WIDTH = uart_pkg::DEFAULT_OP_WIDTH
);
  import uart_pkg::*;

  logic [BYTE_W-1:0]   i_rx_data;
  logic                i_rx_done;
  logic [BYTE_W-1:0]   i_alu_result;
  logic                i_tx_done;
  logic [BYTE_W-1:0]   o_alu_a;
  logic [BYTE_W-1:0]   o_alu_b;
  logic [OP_WIDTH-1:0] o_alu_op;
  logic [BYTE_W-1:0]   o_tx_data;
  logic                o_tx_start;
  logic                o_busy;
  logic                o_overrun;
  logic                o_frame_err;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun, o_frame_err
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun, o_frame_err
  );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts enabled idle cycles, single-cycle expire at TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES=0 pins the counter at zero so it never expires.
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES = uart_pkg::DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam int CW      = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  assign o_expire = ENABLED && i_en && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (!ENABLED || !i_en || i_clr || o_expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes, latches the ALU result and pulses tx start 3 cycles after the opcode byte.
// Bytes arriving while busy are dropped and flagged in a sticky overrun bit.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int OP_WIDTH       = DEFAULT_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  uart_alu_if.master bus
);

  state_t              state, state_nxt;
  logic [BYTE_W-1:0]   a_q, b_q, tx_data_q;
  logic [OP_WIDTH-1:0] op_q;
  logic                tx_start_q, overrun_q, frame_err_q;
  logic                ld_a, ld_b, ld_op, ld_res, send, fire, busy, tmr_en, expire;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_OPA;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    ld_res    = 1'b0;
    send      = 1'b0;
    fire      = 1'b0;
    busy      = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      ST_OPA: begin
        if (bus.i_rx_done) begin
          ld_a      = 1'b1;
          state_nxt = ST_OPB;
        end
      end
      ST_OPB: begin
        tmr_en = 1'b1;
        // A byte in the expiry cycle wins over the timeout.
        if (bus.i_rx_done) begin
          ld_b      = 1'b1;
          state_nxt = ST_OPCODE;
        end else if (expire) begin
          fire      = 1'b1;
          state_nxt = ST_OPA;
        end
      end
      ST_OPCODE: begin
        tmr_en = 1'b1;
        if (bus.i_rx_done) begin
          ld_op     = 1'b1;
          state_nxt = ST_EXEC;
        end else if (expire) begin
          fire      = 1'b1;
          state_nxt = ST_OPA;
        end
      end
      ST_EXEC: begin
        busy      = 1'b1;
        ld_res    = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy      = 1'b1;
        send      = 1'b1;
        state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        busy = 1'b1;
        if (bus.i_tx_done) begin
          state_nxt = ST_OPA;
        end
      end
      default: state_nxt = ST_OPA;
    endcase
  end

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (tmr_en),
    .i_clr    (bus.i_rx_done),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ld_a)   a_q       <= bus.i_rx_data;
      if (ld_b)   b_q       <= bus.i_rx_data;
      if (ld_op)  op_q      <= bus.i_rx_data[OP_WIDTH-1:0];
      if (ld_res) tx_data_q <= bus.i_alu_result;
      tx_start_q  <= send;
      frame_err_q <= fire;
      overrun_q   <= overrun_q | (busy & bus.i_rx_done);
    end
  end

  assign bus.o_alu_a     = a_q;
  assign bus.o_alu_b     = b_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_busy      = busy;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized and directed bench for uart_alu_interface against a cycle-count reference model.
module tb_uart_alu_interface;
  import uart_pkg::*;

  localparam int TO = 16;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  uart_alu_if #(.OP_WIDTH(6)) bus ();

  uart_alu_interface #(
    .OP_WIDTH       (6),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      default:   return a ^ b;
    endcase
  endfunction

  logic tx_done_auto = 1'b0;
  logic tx_done_man  = 1'b0;
  logic auto_tx      = 1'b0;
  assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  assign bus.i_tx_done    = tx_done_auto | tx_done_man;

  // Reference model: counts bytes collected, cycles since the opcode and idle cycles.
  logic [7:0] m_a = 0, m_b = 0, m_tx = 0;
  logic [5:0] m_op = 0;
  logic       m_start = 0, m_busy = 0, m_ovr = 0, m_ferr = 0;
  int         m_got = 0, m_since = 0, m_idle = 0;
  logic       start_n, ferr_n;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
      m_start = 0; m_busy = 0; m_ovr = 0; m_ferr = 0;
      m_got = 0; m_since = 0; m_idle = 0;
    end else begin
      start_n = 1'b0;
      ferr_n  = 1'b0;
      if (m_busy) begin
        if (bus.i_rx_done) m_ovr = 1'b1;
        if (m_since == 0) m_tx = alu(m_a, m_b, m_op);
        else if (m_since == 1) start_n = 1'b1;
        else if (bus.i_tx_done) m_busy = 1'b0;
        m_since++;
      end else if (bus.i_rx_done) begin
        case (m_got)
          0:       m_a  = bus.i_rx_data;
          1:       m_b  = bus.i_rx_data;
          default: m_op = bus.i_rx_data[5:0];
        endcase
        m_idle = 0;
        if (m_got == 2) begin
          m_got = 0; m_busy = 1'b1; m_since = 0;
        end else begin
          m_got++;
        end
      end else if (m_got != 0) begin
        if (m_idle == TO - 1) begin
          m_got = 0; m_idle = 0; ferr_n = 1'b1;
        end else begin
          m_idle++;
        end
      end
      m_start = start_n;
      m_ferr  = ferr_n;
    end
  end

  // Transmitter stand-in for the random phase.
  always begin
    @(negedge i_clk);
    if (auto_tx && bus.o_tx_start) begin
      repeat ($urandom_range(1, 6)) @(posedge i_clk);
      #1 tx_done_auto = 1'b1;
      @(posedge i_clk);
      #1 tx_done_auto = 1'b0;
    end
  end

  int   checks = 0, failures = 0;
  int   n_start = 0, n_ferr = 0;
  logic s_start, s_busy, s_ferr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // One cycle: compare everything against the model at negedge, then step past the next posedge.
  task automatic tick();
    logic [33:0] act, exp;
    @(negedge i_clk);
    act = {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
           bus.o_tx_start, bus.o_busy, bus.o_overrun, bus.o_frame_err};
    exp = {m_a, m_b, m_op, m_tx, m_start, m_busy, m_ovr, m_ferr};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
    end
    s_start = bus.o_tx_start;
    s_busy  = bus.o_busy;
    s_ferr  = bus.o_frame_err;
    n_start += int'(s_start);
    n_ferr  += int'(s_ferr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done_man = 1'b1;
    tick();
    tx_done_man = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lat++;
      if (s_start) break;
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, output int lat);
    send_byte(a); tick();
    send_byte(b); tick();
    send_byte(op);
    wait_start(lat);
    tick();
    pulse_tx_done();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, f0;
    logic [7:0] ops [5];
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'hE0; ops[3] = 8'hE2; ops[4] = 8'h3F;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    tick();
    chk("reset_outputs", {bus.o_alu_a, bus.o_tx_data, 4'(bus.o_busy), 4'(bus.o_tx_start),
                          4'(bus.o_overrun), 4'(bus.o_frame_err)}, 32'h0);
    i_reset = 1'b1;
    tick();

    // Basic add with latency and busy window.
    send_byte(8'h05); tick();
    send_byte(8'h03); tick();
    s0 = n_start;
    send_byte(8'h20);
    wait_start(lat);
    chk("latency", lat, 3);
    chk("add_result", bus.o_tx_data, 8'h08);
    chk("operands", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op}, 24'h050320);
    repeat (3) tick();
    chk("busy_hold", s_busy, 1'b1);
    pulse_tx_done();
    tick();
    chk("busy_clear", s_busy, 1'b0);
    chk("single_start", n_start - s0, 1);

    run_frame(8'h10, 8'h20, 8'h22, lat);
    chk("sub_wrap", bus.o_tx_data, 8'hF0);
    run_frame(8'hFF, 8'h01, 8'h20, lat);
    chk("add_wrap", bus.o_tx_data, 8'h00);
    run_frame(8'h12, 8'h34, 8'hE0, lat);
    chk("op_mask", bus.o_alu_op, 6'b100000);
    chk("op_mask_result", bus.o_tx_data, 8'h46);

    // Stray tx_done while idle.
    s0 = n_start;
    repeat (3) begin pulse_tx_done(); tick(); end
    chk("stray_tx_done", {n_start - s0, 31'(s_busy)}, 0);

    // Timeout after a partial frame.
    s0 = n_start; f0 = n_ferr;
    send_byte(8'h07); tick();
    send_byte(8'h09);
    lat = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (s_ferr) lat = i;
    end
    chk("ferr_count", n_ferr - f0, 1);
    chk("ferr_cycle", lat, TO + 1);
    chk("ferr_no_start", n_start - s0, 0);
    run_frame(8'h02, 8'h03, 8'h22, lat);
    chk("post_timeout", bus.o_tx_data, 8'hFF);

    // Overrun during WAIT_TX, and a byte coinciding with tx_done.
    send_byte(8'h30); tick();
    send_byte(8'h40); tick();
    send_byte(8'h20);
    wait_start(lat);
    send_byte(8'hAA);
    chk("overrun_set", bus.o_overrun, 1'b1);
    bus.i_rx_data = 8'h55;
    bus.i_rx_done = 1'b1;
    tx_done_man   = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    tx_done_man   = 1'b0;
    tick();
    chk("drop_on_done", {bus.o_alu_a, 7'(0), s_busy}, {8'h30, 8'h00});
    run_frame(8'h01, 8'h02, 8'h20, lat);
    chk("after_overrun", bus.o_tx_data, 8'h03);
    chk("overrun_sticky", bus.o_overrun, 1'b1);

    // Asynchronous reset in WAIT_TX.
    send_byte(8'h11); tick();
    send_byte(8'h22); tick();
    send_byte(8'h20);
    wait_start(lat);
    tick();
    #2 i_reset = 1'b0;
    #1;
    chk("arst_regs", {bus.o_alu_a, bus.o_alu_b, bus.o_tx_data, 2'b00, bus.o_alu_op}, 32'h0);
    chk("arst_flags", {bus.o_tx_start, bus.o_busy, bus.o_overrun, bus.o_frame_err}, 4'h0);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    s0 = n_start;
    pulse_tx_done();
    repeat (10) tick();
    chk("arst_no_start", {n_start - s0, 31'(s_busy)}, 0);

    // Random frames with timeouts, overruns and stray tx_done.
    auto_tx = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 3; k++) begin
        send_byte(k == 2 ? ops[$urandom_range(0, 4)] : 8'($urandom));
        repeat (($urandom_range(0, 9) == 0) ? 18 : $urandom_range(0, 3)) tick();
      end
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
      if ($urandom_range(0, 4) == 0) pulse_tx_done();
      tick();
      for (int k = 0; k < 80 && s_busy; k++) tick();
      chk("drain", s_busy, 1'b0);
      repeat (TO + 2) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
